// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer port arbiter.
package fb_pkg;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 8;
  localparam int FB_PIXELS = FB_W * FB_H;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_GPU  = 2'd2
  } owner_t;

  typedef struct packed {
    owner_t owner;
    logic   zero;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

  typedef enum logic {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } swap_state_t;
endpackage

// File: rtl/fb_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; its output lines up with mem_rdata.
module fb_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [fb_pkg::TAG_W-1:0] tag_in,
  output logic [fb_pkg::TAG_W-1:0] tag_out
);
  import fb_pkg::*;

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '{owner: OWN_NONE, zero: 1'b0};
    end else begin
      pipe[0] <= rd_tag_t'(tag_in);
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout priority, GPU round-robin, tear-free buffer swap.
module fb_port_arbiter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank_start,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              front_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import fb_pkg::*;

  localparam int PIXELS = FB_W * FB_H;

  swap_state_t       state;
  logic              rr_rd;
  logic [DATA_W-1:0] disp_rdata_q, rd_rdata_q, ret_data;
  logic              disp_gnt, gpu_free, wr_gnt, rd_gnt, contest;
  logic              disp_in, wr_in, rd_in;
  rd_tag_t           tag_in, tag_out;

  assign disp_in  = 32'(disp_addr) < 32'(PIXELS);
  assign wr_in    = 32'(wr_addr)   < 32'(PIXELS);
  assign rd_in    = 32'(rd_addr)   < 32'(PIXELS);

  // rr_rd=1 means the read side wins the next contested cycle
  assign disp_gnt = rst_n & disp_req;
  assign gpu_free = rst_n & ~disp_req;
  assign contest  = gpu_free & wr_valid & rd_valid;
  assign wr_gnt   = gpu_free & wr_valid & (~rd_valid | ~rr_rd);
  assign rd_gnt   = gpu_free & rd_valid & (~wr_valid | rr_rd);
  assign wr_ready = wr_gnt;
  assign rd_ready = rd_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_gnt) begin
      mem_en   = disp_in;
      mem_addr = {front_sel, disp_addr};
    end else if (wr_gnt) begin
      mem_en    = wr_in;
      mem_we    = 1'b1;
      mem_addr  = {~front_sel, wr_addr};
      mem_wdata = wr_data;
    end else if (rd_gnt) begin
      mem_en   = rd_in;
      mem_addr = {~front_sel, rd_addr};
    end
  end

  always_comb begin
    tag_in.owner = OWN_NONE;
    tag_in.zero  = 1'b0;
    if (disp_gnt) begin
      tag_in.owner = OWN_DISP;
      tag_in.zero  = ~disp_in;
    end else if (rd_gnt) begin
      tag_in.owner = OWN_GPU;
      tag_in.zero  = ~rd_in;
    end
  end

  fb_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Return data is presented in the same cycle mem_rdata arrives; the held copy covers idle cycles
  assign ret_data    = tag_out.zero ? '0 : mem_rdata;
  assign disp_rvalid = (tag_out.owner == OWN_DISP);
  assign rd_rvalid   = (tag_out.owner == OWN_GPU);
  assign disp_rdata  = disp_rvalid ? ret_data : disp_rdata_q;
  assign rd_rdata    = rd_rvalid   ? ret_data : rd_rdata_q;

  assign swap_pending = rst_n & ((state == SW_PENDING) | (swap_req & vblank_start));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SW_IDLE;
      front_sel    <= 1'b0;
      rr_rd        <= 1'b0;
      disp_rdata_q <= '0;
      rd_rdata_q   <= '0;
    end else begin
      if (contest) rr_rd <= ~rr_rd;
      if (disp_rvalid) disp_rdata_q <= ret_data;
      if (rd_rvalid)   rd_rdata_q   <= ret_data;
      case (state)
        SW_IDLE: begin
          if (swap_req) begin
            if (vblank_start) front_sel <= ~front_sel;
            else              state     <= SW_PENDING;
          end
        end
        SW_PENDING: begin
          if (vblank_start) begin
            front_sel <= ~front_sel;
            state     <= SW_IDLE;
          end
        end
        default: state <= SW_IDLE;
      endcase
    end
  end
endmodule
